bcd_to_bin: RTL and testbench

//  Sequential BCD-to-binary converter (reverse double dabble); inverse of the

---
 rtl/bcd_to_bin.sv | 132 +++++++++++++
 tb/tb_bcd_to_bin.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_bin.sv
// Sequential BCD-to-binary converter (reverse double dabble) with start/busy/done handshake.
// Define BCD2BIN_SAT_EN to saturate bin_out on overflow; otherwise the result is truncated.

// state   | meaning
// S_IDLE  | waiting for start; captures bcd_in and validates its digits
// S_SHIFT | one right shift plus nibble correction per cycle, N_SHIFT cycles
// S_FIN   | registers bin_out/ovf/err and pulses done for one cycle
module bcd_to_bin #(
    parameter int DIGITS  = 3,
    parameter int N_SHIFT = 10,
    parameter int BIN_W   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  ovf,
    output logic                  err
);

    localparam int BCD_W  = 4 * DIGITS;
    localparam int SR_W   = BCD_W + N_SHIFT;
    localparam int ITER_W = $clog2(N_SHIFT + 1);
    localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(N_SHIFT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_FIN
    } state_t;

    state_t             state;
    logic [SR_W-1:0]    sr;
    logic [ITER_W-1:0]  iter;
    logic               bad_cap;

    logic [SR_W-1:0]    sr_shifted;
    logic [SR_W-1:0]    sr_next;
    logic               bad_digit;
    logic [N_SHIFT-1:0] val;
    logic               val_ovf;
    logic [BIN_W-1:0]   bin_res;

    // Shift first, then pull 3 out of any BCD nibble that picked up a carried-in 8.
    always_comb begin
        sr_shifted = sr >> 1;
        sr_next    = sr_shifted;
        for (int d = 0; d < DIGITS; d++) begin
            if (sr_shifted[N_SHIFT + 4*d + 3]) begin
                sr_next[N_SHIFT + 4*d +: 4] = sr_shifted[N_SHIFT + 4*d +: 4] - 4'd3;
            end
        end
    end

    always_comb begin
        bad_digit = 1'b0;
        for (int d = 0; d < DIGITS; d++) begin
            if (bcd_in[4*d +: 4] > 4'd9) begin
                bad_digit = 1'b1;
            end
        end
    end

    assign val     = sr[N_SHIFT-1:0];
    assign val_ovf = (val >> BIN_W) != '0;

`ifdef BCD2BIN_SAT_EN
    assign bin_res = val_ovf ? {BIN_W{1'b1}} : val[BIN_W-1:0];
`else
    assign bin_res = val[BIN_W-1:0];
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            sr      <= '0;
            iter    <= '0;
            bad_cap <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            bin_out <= '0;
            ovf     <= 1'b0;
            err     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sr   <= {bcd_in, {N_SHIFT{1'b0}}};
                        iter <= '0;
                        if (bad_digit) begin
                            bad_cap <= 1'b1;
                            state   <= S_FIN;
                        end else begin
                            bad_cap <= 1'b0;
                            busy    <= 1'b1;
                            state   <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    sr   <= sr_next;
                    iter <= iter + ITER_W'(1);
                    if (iter == ITER_LAST) begin
                        state <= S_FIN;
                    end
                end
                S_FIN: begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    if (bad_cap) begin
                        bin_out <= '0;
                        ovf     <= 1'b0;
                        err     <= 1'b1;
                    end else begin
                        bin_out <= bin_res;
                        ovf     <= val_ovf;
                        err     <= 1'b0;
                    end
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_to_bin.sv
// Directed, table-driven bench for bcd_to_bin (DIGITS=3, N_SHIFT=10, BIN_W=8).
// Expected values are hand-computed; saturating expectations follow BCD2BIN_SAT_EN.
module tb_bcd_to_bin;

    logic        clk;
    logic        rst;
    logic        start;
    logic [11:0] bcd_in;
    logic        busy;
    logic        done;
    logic [7:0]  bin_out;
    logic        ovf;
    logic        err;

    int checks   = 0;
    int failures = 0;

    bcd_to_bin #(.DIGITS(3), .N_SHIFT(10), .BIN_W(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .bcd_in  (bcd_in),
        .busy    (busy),
        .done    (done),
        .bin_out (bin_out),
        .ovf     (ovf),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] bcd;
        logic [7:0]  exp_bin;
        logic        exp_ovf;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Pulses start for one cycle; reports latency in cycles from the capture edge.
    task automatic run(input logic [11:0] b, output int lat, output logic busy_first,
                       output logic saw_busy, output logic [7:0] hold_bin, output logic done_after);
        @(negedge clk);
        bcd_in = b;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start      = 1'b0;
        busy_first = busy;
        saw_busy   = busy;
        hold_bin   = bin_out;
        lat        = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (busy) saw_busy = 1'b1;
            if (done) begin
                lat = n;
                break;
            end
        end
        @(posedge clk);
        #1;
        done_after = done;
    endtask

    vec_t        vecs[13];
    int          lat;
    logic        bf, sb, da;
    logic [7:0]  hb;
    logic [7:0]  prev_bin;
    int          dones;
    int          first_done;

    initial begin
        vecs[0]  = '{12'h255, 8'hFF, 1'b0, 1'b0, 11};
`ifdef BCD2BIN_SAT_EN
        vecs[1]  = '{12'h999, 8'hFF, 1'b1, 1'b0, 11};
        vecs[9]  = '{12'h256, 8'hFF, 1'b1, 1'b0, 11};
`else
        vecs[1]  = '{12'h999, 8'hE7, 1'b1, 1'b0, 11};
        vecs[9]  = '{12'h256, 8'h00, 1'b1, 1'b0, 11};
`endif
        vecs[2]  = '{12'h000, 8'h00, 1'b0, 1'b0, 11};
        vecs[3]  = '{12'h128, 8'h80, 1'b0, 1'b0, 11};
        vecs[4]  = '{12'h1A5, 8'h00, 1'b0, 1'b1, 1};
        vecs[5]  = '{12'h042, 8'h2A, 1'b0, 1'b0, 11};
        vecs[6]  = '{12'h099, 8'h63, 1'b0, 1'b0, 11};
        vecs[7]  = '{12'h09F, 8'h00, 1'b0, 1'b1, 1};
        vecs[8]  = '{12'h100, 8'h64, 1'b0, 1'b0, 11};
        vecs[10] = '{12'hA00, 8'h00, 1'b0, 1'b1, 1};
        vecs[11] = '{12'h007, 8'h07, 1'b0, 1'b0, 11};
        vecs[12] = '{12'h199, 8'hC7, 1'b0, 1'b0, 11};

        rst    = 1'b0;
        start  = 1'b0;
        bcd_in = 12'h000;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_bin",  {24'b0, bin_out}, 32'd0);
        check("reset_ovf",  {31'b0, ovf}, 32'd0);
        check("reset_err",  {31'b0, err}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        prev_bin = 8'h00;
        for (int i = 0; i < 13; i++) begin
            run(vecs[i].bcd, lat, bf, sb, hb, da);
            check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
            check($sformatf("v%0d_bin", i), {24'b0, bin_out}, {24'b0, vecs[i].exp_bin});
            check($sformatf("v%0d_ovf", i), {31'b0, ovf}, {31'b0, vecs[i].exp_ovf});
            check($sformatf("v%0d_err", i), {31'b0, err}, {31'b0, vecs[i].exp_err});
            check($sformatf("v%0d_busy_first", i), {31'b0, bf}, {31'b0, ~vecs[i].exp_err});
            check($sformatf("v%0d_busy_seen", i), {31'b0, sb}, {31'b0, ~vecs[i].exp_err});
            check($sformatf("v%0d_bin_held", i), {24'b0, hb}, {24'b0, prev_bin});
            check($sformatf("v%0d_done_pulse", i), {31'b0, da}, 32'd0);
            prev_bin = vecs[i].exp_bin;
        end

        // Restart attempt and bcd_in change mid-conversion must be ignored.
        @(negedge clk);
        bcd_in = 12'h042;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        dones = 0;
        first_done = 0;
        for (int n = 1; n <= 30; n++) begin
            if (n == 3) begin
                start  = 1'b1;
                bcd_in = 12'h999;
            end
            if (n == 4) begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            if (done) begin
                dones++;
                if (first_done == 0) first_done = n;
            end
        end
        check("ignore_start_dones", dones, 1);
        check("ignore_start_latency", first_done, 11);
        check("ignore_start_bin", {24'b0, bin_out}, 32'h2A);

        // Start held high: back-to-back conversions, one IDLE cycle apart.
        @(negedge clk);
        bcd_in = 12'h005;
        start  = 1'b1;
        @(posedge clk);
        dones = 0;
        for (int n = 1; n <= 23; n++) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("held_start_dones", dones, 2);
        check("held_start_bin", {24'b0, bin_out}, 32'h05);
        check("held_start_idle", {31'b0, busy}, 32'd0);

        // Reset mid-conversion: outputs clear at once, no done follows.
        run(12'h128, lat, bf, sb, hb, da);
        check("pre_abort_bin", {24'b0, bin_out}, 32'h80);
        @(negedge clk);
        bcd_in = 12'h200;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_done", {31'b0, done}, 32'd0);
        check("abort_bin",  {24'b0, bin_out}, 32'd0);
        check("abort_ovf",  {31'b0, ovf}, 32'd0);
        check("abort_err",  {31'b0, err}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        dones = 0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk);
            #1;
            if (done || busy) dones++;
        end
        check("abort_no_done", dones, 0);
        run(12'h007, lat, bf, sb, hb, da);
        check("after_abort_latency", lat, 11);
        check("after_abort_bin", {24'b0, bin_out}, 32'h07);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
